grid_line_plotter: RTL and testbench
====================================

// Module: grid_line_plotter
// PURPOSE
//  Parametrised successor to the fixed 4x4 grid drawer. On a start pulse it
//  walks every horizontal, then every vertical, line of a GRID_N x GRID_N
//  grid, one pixel per clock, with a plot strobe, and raises done when
//  finished. Sits between the game-state FSM and the VGA adapter write port.
//  Adds start/done handshake, stall, per-run colour (erase) and origin offset.
// PARAMETERS
//  GRID_N   4      cells per side; GRID_N+1 lines per direction
//  CELL_PX  29     pixel pitch between adjacent lines
//  X0       0      x of grid top-left corner
//  Y0       0      y of grid top-left corner
//  XW       8      x coordinate width
//  YW       7      y coordinate width
//  CW       3      colour width
// PORTS
//  clk        in   1    clock
//  resetn     in   1    synchronous active-low reset
//  start      in   1    one-cycle request; sampled only in IDLE
//  color_in   in   CW   colour for this run (background colour = erase)
//  stall      in   1    1 = hold current pixel, plot forced 0
//  plot       out  1    1 = x_out/y_out/color_out valid this cycle
//  x_out      out  XW   pixel x
//  y_out      out  YW   pixel y
//  color_out  out  CW   latched color_in
//  busy       out  1    run in progress
//  done       out  1    one-cycle pulse after last pixel
// BEHAVIOUR
//  - Reset (clk edge, resetn=0): state IDLE; plot, busy, done, x_out, y_out,
//    color_out all 0. Reset mid-run aborts immediately, no done pulse.
//  - L = GRID_N*CELL_PX + 1 pixels per line (default 117, 0..116).
//    NL = GRID_N+1 lines per pass. Total pixels P = 2*NL*L (default 1170).
//  - States: IDLE -> HLINE -> VLINE -> FIN -> IDLE.
//    IDLE: start=1 latches color_in, clears k (line index) and i (pixel index);
//      next state HLINE. busy rises the cycle after start.
//    HLINE: x = X0+i, y = Y0+k*CELL_PX. i counts 0..L-1; at i=L-1, i->0, k++;
//      at k=NL-1 and i=L-1 -> VLINE with k=0.
//    VLINE: x = X0+k*CELL_PX, y = Y0+i; same counting; last pixel -> FIN.
//    FIN: done=1, busy=0, plot=0 for exactly one cycle; -> IDLE.
//  - Line base k*CELL_PX held in an accumulator (add CELL_PX per line); no
//    multiplier.
//  - Outputs registered: first pixel (X0,Y0) appears with plot=1 on the cycle
//    after the start edge. Without stall, plot is high P consecutive cycles.
//  - stall=1 in HLINE/VLINE: counters and coordinates frozen, plot=0; on
//    release the frozen pixel is emitted (no pixel skipped or duplicated).
//    stall ignored in IDLE/FIN.
//  - start while busy or in FIN: ignored; color_out stays at latched value.
//  - Corner pixels are emitted in both passes (duplicate writes are legal).
//  - Width rule: X0+GRID_N*CELL_PX < 2^XW and Y0+GRID_N*CELL_PX < 2^YW;
//    violation is a configuration error (elaboration-time check in bench).
//    Counters sized $clog2(L); no wrap permitted within a run.
//  - color_out updates only on accepted start; holds after done.
// TESTING
//  1 Defaults, start pulse, color_in=3'b111 -> 1170 plot cycles, first
//    (0,0), pixel 117 = (0,29), pixel 584 = (116,116), pixel 585 = (0,0) v-pass,
//    last (116,116); done one cycle later; busy low with done.
//  2 Scoreboard: set of plotted pixels equals exactly {x or y in
//    {0,29,58,87,116}, other in 0..116}; no off-grid pixel.
//  3 stall high 10 cycles at pixel 300 -> plot 0 during stall, pixel 300
//    resumes unchanged, total plot count still 1170, done delayed by 10.
//  4 start pulsed at pixels 5 and 1000 with color_in=3'b000 -> ignored;
//    color_out stays 3'b111, count 1170.
//  5 resetn low at pixel 700 -> next cycle plot/busy/done/x/y = 0, no done;
//    new start runs full 1170 from (0,0).
//  6 GRID_N=3, CELL_PX=10, X0=20, Y0=5 -> L=31, P=248, first (20,5), last
//    h-line pixel (50,35), done after 248 plots.

Source files
------------

// File: rtl/grid_line_plotter.sv
// Walks every horizontal then every vertical line of a GRID_N x GRID_N grid,
// one pixel per clock, with stall, per-run colour and origin offset.
module grid_line_plotter #(
   parameter int GRID_N  = 4,
   parameter int CELL_PX = 29,
   parameter int X0      = 0,
   parameter int Y0      = 0,
   parameter int XW      = 8,
   parameter int YW      = 7,
   parameter int CW      = 3
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic [CW-1:0] color_in,
   input  logic          stall,
   output logic          plot,
   output logic [XW-1:0] x_out,
   output logic [YW-1:0] y_out,
   output logic [CW-1:0] color_out,
   output logic          busy,
   output logic          done
);
   localparam int L  = GRID_N*CELL_PX + 1;
   localparam int NL = GRID_N + 1;
   localparam int IW = $clog2(L);
   localparam int KW = $clog2(NL);
   localparam int BW = $clog2(GRID_N*CELL_PX + 1);

   typedef enum logic [1:0] {IDLE, HLINE, VLINE, FIN} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   i_q, i_d;
   logic [KW-1:0]   k_q, k_d;
   logic [BW-1:0]   base_q, base_d;
   logic            last_q, last_d;
   logic            plot_q, plot_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [CW-1:0]   color_q, color_d;

   // Counters address the next pixel to issue; the output registers hold the
   // pixel issued on the previous edge, so a stall simply withholds issuing.
   logic            cur_v, issue;
   logic [IW-1:0]   cur_i;
   logic [KW-1:0]   cur_k;
   logic [BW-1:0]   cur_base;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         i_q     <= '0;
         k_q     <= '0;
         base_q  <= '0;
         last_q  <= 1'b0;
         plot_q  <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         k_q     <= k_d;
         base_q  <= base_d;
         last_q  <= last_d;
         plot_q  <= plot_d;
         x_q     <= x_d;
         y_q     <= y_d;
         color_q <= color_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      k_d      = k_q;
      base_d   = base_q;
      last_d   = last_q;
      plot_d   = 1'b0;
      x_d      = x_q;
      y_d      = y_q;
      color_d  = color_q;
      cur_v    = (state_q == VLINE);
      cur_i    = i_q;
      cur_k    = k_q;
      cur_base = base_q;
      issue    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               color_d  = color_in;
               cur_v    = 1'b0;
               cur_i    = '0;
               cur_k    = '0;
               cur_base = '0;
               last_d   = 1'b0;
               issue    = 1'b1;
            end
         end
         HLINE, VLINE: begin
            if (last_q) begin
               state_d = FIN;
               last_d  = 1'b0;
            end else if (!stall) begin
               issue = 1'b1;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (issue) begin
         plot_d  = 1'b1;
         x_d     = XW'(X0) + (cur_v ? XW'(cur_base) : XW'(cur_i));
         y_d     = YW'(Y0) + (cur_v ? YW'(cur_i) : YW'(cur_base));
         state_d = cur_v ? VLINE : HLINE;
         if (cur_i == IW'(L-1)) begin
            i_d = '0;
            if (cur_k == KW'(NL-1)) begin
               k_d    = '0;
               base_d = '0;
               if (cur_v) last_d  = 1'b1;
               else       state_d = VLINE;
            end else begin
               k_d    = cur_k + KW'(1);
               base_d = cur_base + BW'(CELL_PX);
            end
         end else begin
            i_d = cur_i + IW'(1);
         end
      end
   end

   assign plot      = plot_q;
   assign x_out     = x_q;
   assign y_out     = y_q;
   assign color_out = color_q;
   assign busy      = (state_q == HLINE) || (state_q == VLINE);
   assign done      = (state_q == FIN);
endmodule

// File: tb/tb_grid_line_plotter.sv
// Directed bench: default grid (A) and a small offset grid (B) checked against
// a division-based pixel-order model plus key-pixel tables.
module tb_grid_line_plotter;
   localparam int GA = 4,  CA = 29, XA = 0,  YA = 0;
   localparam int GB = 3,  CB = 10, XB = 20, YB = 5;

   if ((XA + GA*CA >= 256) || (YA + GA*CA >= 128) ||
       (XB + GB*CB >= 256) || (YB + GB*CB >= 128)) begin : g_bad_cfg
      initial $fatal(1, "FAIL cfg_width: grid does not fit coordinate widths");
   end

   logic       clk = 1'b0, resetn = 1'b0;
   logic       start_a = 1'b0, start_b = 1'b0, stall_a = 1'b0, stall_b = 1'b0;
   logic [2:0] color_in = 3'b000;
   logic       plot_a, busy_a, done_a, plot_b, busy_b, done_b;
   logic [7:0] x_a, x_b;
   logic [6:0] y_a, y_b;
   logic [2:0] col_a, col_b;

   grid_line_plotter #(.GRID_N(GA), .CELL_PX(CA), .X0(XA), .Y0(YA)) u_a (
      .clk(clk), .resetn(resetn), .start(start_a), .color_in(color_in),
      .stall(stall_a), .plot(plot_a), .x_out(x_a), .y_out(y_a),
      .color_out(col_a), .busy(busy_a), .done(done_a));

   grid_line_plotter #(.GRID_N(GB), .CELL_PX(CB), .X0(XB), .Y0(YB)) u_b (
      .clk(clk), .resetn(resetn), .start(start_b), .color_in(color_in),
      .stall(stall_b), .plot(plot_b), .x_out(x_b), .y_out(y_b),
      .color_out(col_b), .busy(busy_b), .done(done_b));

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int cx [0:1299];
   int cy [0:1299];

   typedef struct { int idx; int x; int y; } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void exp_pix(input int n, input int gn, input int cp,
                                   input int x0, input int y0, output int x, output int y);
      int l, nl, m;
      l  = gn*cp + 1;
      nl = gn + 1;
      m  = n % (nl*l);
      if (n < nl*l) begin x = x0 + m % l;        y = y0 + (m / l)*cp; end
      else          begin x = x0 + (m / l)*cp;   y = y0 + m % l;      end
   endfunction

   function automatic int seq_errs(input int n, input int gn, input int cp,
                                   input int x0, input int y0);
      int e, ex, ey;
      e = 0;
      for (int p = 0; p < n; p++) begin
         exp_pix(p, gn, cp, x0, y0, ex, ey);
         if (cx[p] != ex || cy[p] != ey) e++;
      end
      return e;
   endfunction

   // One run from a start pulse; returns at the done cycle, when the cycle
   // budget runs out, or (reset_at) right after that many pixels were seen.
   task automatic run(input bit sel, input int stall_at, input int rs1, input int rs2,
                      input int reset_at, output int nplot, output int ncyc,
                      output bit got_done, output int busy1, output int st_plot,
                      output int st_xy_bad);
      int  sc;
      bit  sprev, r1, r2;
      int  p, b, d, xx, yy;
      nplot = 0; ncyc = 0; got_done = 0; busy1 = 0; st_plot = 0; st_xy_bad = 0;
      sc = 0; sprev = 0; r1 = 0; r2 = 0;
      @(negedge clk);
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      color_in = 3'b111;
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0; color_in = 3'b010;
      while (ncyc < 3000) begin
         ncyc++;
         p  = sel ? int'(plot_b) : int'(plot_a);
         b  = sel ? int'(busy_b) : int'(busy_a);
         d  = sel ? int'(done_b) : int'(done_a);
         xx = sel ? int'(x_b)    : int'(x_a);
         yy = sel ? int'(y_b)    : int'(y_a);
         if (ncyc == 1) busy1 = b;
         if (sprev) begin
            if (p != 0) st_plot++;
            if (nplot > 0 && (xx != cx[nplot-1] || yy != cy[nplot-1])) st_xy_bad++;
         end
         if (d != 0) begin got_done = 1; break; end
         if (p != 0) begin
            if (nplot < 1300) begin cx[nplot] = xx; cy[nplot] = yy; end
            nplot++;
         end
         if (nplot == reset_at) break;
         start_a = 1'b0; stall_a = 1'b0; sprev = 1'b0; color_in = 3'b010;
         if (nplot == stall_at && sc < 10) begin stall_a = 1'b1; sc++; sprev = 1'b1; end
         if (nplot == rs1 && !r1) begin start_a = 1'b1; color_in = 3'b000; r1 = 1; end
         if (nplot == rs2 && !r2) begin start_a = 1'b1; color_in = 3'b000; r2 = 1; end
         @(negedge clk);
      end
      start_a = 1'b0; stall_a = 1'b0;
   endtask

   initial begin
      vec_t va [5];
      vec_t vb [5];
      int   np, nc, b1, sp, sxy, off, uniq, ln;
      bit   gd;
      bit   seen [0:255][0:127];

      va[0] = '{0,    0,   0};
      va[1] = '{117,  0,   29};
      va[2] = '{584,  116, 116};
      va[3] = '{585,  0,   0};
      va[4] = '{1169, 116, 116};
      vb[0] = '{0,    20, 5};
      vb[1] = '{30,   50, 5};
      vb[2] = '{123,  50, 35};
      vb[3] = '{124,  20, 5};
      vb[4] = '{247,  50, 35};

      // reset state
      @(negedge clk); @(negedge clk);
      chk("rst_plot", int'(plot_a), 0);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_done", int'(done_a), 0);
      chk("rst_xy",   int'(x_a) + int'(y_a), 0);
      chk("rst_color", int'(col_a), 0);
      resetn = 1'b1;

      // 1: plain run
      run(0, -1, -1, -1, -1, np, nc, gd, b1, sp, sxy);
      chk("t1_done_seen", int'(gd), 1);
      chk("t1_plots", np, 1170);
      chk("t1_done_cycle", nc, 1171);
      chk("t1_busy_at_done", int'(busy_a), 0);
      chk("t1_busy_first", b1, 1);
      chk("t1_color", int'(col_a), 7);
      for (int v = 0; v < 5; v++) begin
         chk($sformatf("t1_px%0d_x", va[v].idx), cx[va[v].idx], va[v].x);
         chk($sformatf("t1_px%0d_y", va[v].idx), cy[va[v].idx], va[v].y);
      end
      chk("t1_seq", seq_errs(np, GA, CA, XA, YA), 0);
      @(negedge clk);
      chk("t1_done_pulse", int'(done_a), 0);

      // 2: pixel set is exactly the grid
      off = 0; uniq = 0;
      for (int xi = 0; xi < 256; xi++) for (int yi = 0; yi < 128; yi++) seen[xi][yi] = 0;
      for (int p = 0; p < np && p < 1300; p++) begin
         ln = 0;
         for (int k = 0; k <= GA; k++) if (cx[p] == k*CA || cy[p] == k*CA) ln = 1;
         if (ln == 0 || cx[p] > 116 || cy[p] > 116) off++;
         else if (!seen[cx[p]][cy[p]]) begin seen[cx[p]][cy[p]] = 1; uniq++; end
      end
      chk("t2_offgrid", off, 0);
      chk("t2_distinct", uniq, 1145);

      // 3: stall 10 cycles before pixel 300
      run(0, 300, -1, -1, -1, np, nc, gd, b1, sp, sxy);
      chk("t3_plots", np, 1170);
      chk("t3_done_cycle", nc, 1181);
      chk("t3_plot_in_stall", sp, 0);
      chk("t3_frozen_xy", sxy, 0);
      chk("t3_seq", seq_errs(np, GA, CA, XA, YA), 0);

      // 4: starts while busy are ignored
      run(0, -1, 5, 1000, -1, np, nc, gd, b1, sp, sxy);
      chk("t4_plots", np, 1170);
      chk("t4_done_cycle", nc, 1171);
      chk("t4_color", int'(col_a), 7);
      chk("t4_seq", seq_errs(np, GA, CA, XA, YA), 0);

      // 5: reset mid-run aborts without done
      run(0, -1, -1, -1, 700, np, nc, gd, b1, sp, sxy);
      chk("t5_plots_before", np, 700);
      resetn = 1'b0;
      @(negedge clk);
      chk("t5_rst_plot", int'(plot_a), 0);
      chk("t5_rst_busy", int'(busy_a), 0);
      chk("t5_rst_xy", int'(x_a) + int'(y_a), 0);
      resetn = 1'b1;
      gd = 0;
      for (int c = 0; c < 5; c++) begin
         if (done_a) gd = 1;
         @(negedge clk);
      end
      chk("t5_no_done", int'(gd), 0);
      run(0, -1, -1, -1, -1, np, nc, gd, b1, sp, sxy);
      chk("t5_rerun_plots", np, 1170);
      chk("t5_rerun_seq", seq_errs(np, GA, CA, XA, YA), 0);

      // 6: small offset grid
      run(1, -1, -1, -1, -1, np, nc, gd, b1, sp, sxy);
      chk("t6_plots", np, 248);
      chk("t6_done_cycle", nc, 249);
      chk("t6_color", int'(col_b), 7);
      for (int v = 0; v < 5; v++) begin
         chk($sformatf("t6_px%0d_x", vb[v].idx), cx[vb[v].idx], vb[v].x);
         chk($sformatf("t6_px%0d_y", vb[v].idx), cy[vb[v].idx], vb[v].y);
      end
      chk("t6_seq", seq_errs(np, GB, CB, XB, YB), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
